window_frame_arbiter: RTL and testbench



---
 rtl/window_pkg.sv | 14 +
 rtl/round_robin_picker.sv | 23 ++
 rtl/window_frame_arbiter.sv | 110 +++++++++++
 tb/tb_window_frame_arbiter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/window_pkg.sv
// window_pkg: shared state codes, width helper and default-geometry typedefs for the frame arbiter
package window_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_STREAM = 2'd1, ST_FLUSH = 2'd2;
  typedef logic [1:0] state_t;
  function automatic int cw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int NUM_SOURCES = 4;
  localparam int IN_HEIGHT = 600;
  localparam int IN_WIDTH = 800;
  typedef logic [cw(IN_HEIGHT)-1:0] row_t;
  typedef logic [cw(IN_WIDTH)-1:0] col_t;
  typedef logic [cw(NUM_SOURCES)-1:0] src_t;
endpackage

// File: rtl/round_robin_picker.sv
// round_robin_picker: first requester after last_i, with wrap-around
module round_robin_picker
  import window_pkg::*;
#(
  parameter int N = 4,
  localparam int W = cw(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] next_o,
  output logic         found_o
);
  always_comb begin
    next_o = last_i;
    found_o = 1'b0;
    for (int i = N; i >= 1; i--) begin
      if (req_i[(int'(last_i) + i) % N]) begin
        next_o = W'((int'(last_i) + i) % N);
        found_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/window_frame_arbiter.sv
// window_frame_arbiter: whole-frame round-robin arbiter; optional stall flush via WINDOW_FRAME_ARBITER_FLUSH_EN
module window_frame_arbiter
  import window_pkg::*;
#(
  parameter int NumSources = NUM_SOURCES,
  parameter int InHeight = IN_HEIGHT,
  parameter int InWidth = IN_WIDTH,
  parameter int DataWidth = 8,
  parameter int FlushTimeout = 1024,
  localparam int SW = cw(NumSources),
  localparam int RW = cw(InHeight),
  localparam int CW = cw(InWidth)
) (
  input  logic                            clock_i,
  input  logic                            reset_i,
  input  logic [NumSources-1:0]           src_valid_i,
  output logic [NumSources-1:0]           src_ready_o,
  input  logic [NumSources*DataWidth-1:0] src_data_i,
  output logic                            master_valid_o,
  input  logic                            master_ready_i,
  output logic [DataWidth-1:0]            master_data_o,
  output logic [SW-1:0]                   grant_o,
  output logic                            busy_o,
  output logic                            frame_done_o,
  output logic                            flushed_o
);
  state_t state_q, state_d;
  logic [SW-1:0] grant_q, grant_d, pick;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic done_q, done_d, found, stream, flush, hs, col_end, frame_end;
  round_robin_picker #(.N(NumSources)) u_pick (
    .req_i(src_valid_i),
    .last_i(grant_q),
    .next_o(pick),
    .found_o(found)
  );
  assign stream = state_q == ST_STREAM;
`ifdef WINDOW_FRAME_ARBITER_FLUSH_EN
  localparam int TW = cw(FlushTimeout + 1);
  logic [TW-1:0] stall_q, stall_d;
  logic flushed_q, flushed_d;
  assign flush = state_q == ST_FLUSH;
  assign flushed_o = flushed_q;
`else
  assign flush = 1'b0;
  assign flushed_o = 1'b0;
`endif
  assign master_valid_o = stream ? src_valid_i[grant_q] : flush;
  assign master_data_o = stream ? src_data_i[grant_q*DataWidth +: DataWidth] : '0;
  assign src_ready_o = stream ? (NumSources'(master_ready_i) << grant_q) : '0;
  assign hs = master_valid_o && master_ready_i;
  assign col_end = col_q == CW'(InWidth - 1);
  assign frame_end = col_end && row_q == RW'(InHeight - 1);
  assign grant_o = grant_q;
  assign busy_o = state_q != ST_IDLE;
  assign frame_done_o = done_q;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    row_d = row_q;
    col_d = col_q;
    done_d = 1'b0;
    if (state_q == ST_IDLE && found) begin
      grant_d = pick;
      state_d = ST_STREAM;
    end
    if (hs) begin
      col_d = col_end ? '0 : col_q + 1'b1;
      row_d = frame_end ? '0 : col_end ? row_q + 1'b1 : row_q;
      state_d = frame_end ? ST_IDLE : state_q;
      done_d = frame_end;
    end
  end
`ifdef WINDOW_FRAME_ARBITER_FLUSH_EN
  always_comb begin
    flushed_d = hs && frame_end && flush;
    stall_d = !stream || hs ? '0 : !src_valid_i[grant_q] ? stall_q + 1'b1 : stall_q;
  end
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      stall_q <= '0;
      flushed_q <= 1'b0;
    end else begin
      state_q <= stream && stall_d == TW'(FlushTimeout) ? ST_FLUSH : state_d;
      stall_q <= stall_d == TW'(FlushTimeout) ? '0 : stall_d;
      flushed_q <= flushed_d;
    end
  end
`else
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) state_q <= ST_IDLE;
    else state_q <= state_d;
  end
`endif
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      grant_q <= SW'(NumSources - 1);
      row_q <= '0;
      col_q <= '0;
      done_q <= 1'b0;
    end else begin
      grant_q <= grant_d;
      row_q <= row_d;
      col_q <= col_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_window_frame_arbiter.sv
// tb_window_frame_arbiter: directed and random stimulus against a pixel-count reference model
module tb_window_frame_arbiter;
  localparam int N = 2, H = 3, W = 4, DW = 8, FT = 4, PIX = H * W;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] src_valid_i = '0, src_ready_o;
  logic [N*DW-1:0] src_data_i = '0;
  logic master_valid_o, master_ready_i = 1'b0, busy_o, frame_done_o, flushed_o;
  logic [DW-1:0] master_data_o;
  logic [0:0] grant_o;
  int vecs = 0, errs = 0;
  int m_busy, m_grant, m_cnt, m_done, m_flushing, m_stall, m_flushed;
  logic [DW-1:0] pix [N];
  window_frame_arbiter #(
    .NumSources(N), .InHeight(H), .InWidth(W), .DataWidth(DW), .FlushTimeout(FT)
  ) dut (
    .clock_i(clk), .reset_i(rst_n), .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
    .src_data_i(src_data_i), .master_valid_o(master_valid_o), .master_ready_i(master_ready_i),
    .master_data_o(master_data_o), .grant_o(grant_o), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .flushed_o(flushed_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_busy = 0; m_grant = N - 1; m_cnt = 0; m_done = 0;
    m_flushing = 0; m_stall = 0; m_flushed = 0;
  endtask
  task automatic step(input logic [N-1:0] v, input logic r);
    logic mv, hs;
    logic [N-1:0] rdy;
    logic [DW-1:0] md;
    src_valid_i = v;
    master_ready_i = r;
    for (int k = 0; k < N; k++) src_data_i[k*DW +: DW] = pix[k];
    mv = m_busy != 0 && (m_flushing != 0 || v[m_grant]);
    md = m_busy != 0 && m_flushing == 0 ? pix[m_grant] : '0;
    rdy = m_busy != 0 && m_flushing == 0 ? (N'(r) << m_grant) : '0;
    hs = mv && r;
    #1;
    chk("master_valid", 32'(master_valid_o), 32'(mv));
    if (m_busy != 0) chk("master_data", 32'(master_data_o), 32'(md));
    chk("src_ready", 32'(src_ready_o), 32'(rdy));
    chk("grant", 32'(grant_o), 32'(m_grant));
    chk("busy", 32'(busy_o), 32'(m_busy));
    chk("frame_done", 32'(frame_done_o), 32'(m_done));
    chk("flushed", 32'(flushed_o), 32'(m_flushed));
    @(posedge clk);
    m_done = 0;
    m_flushed = 0;
    if (m_busy == 0) begin
      for (int k = N; k >= 1; k--)
        if (v[(m_grant + k) % N]) begin
          m_busy = 1;
          m_cnt = 0;
          m_stall = 0;
          m_grant = (m_grant + k) % N;
        end
      if (m_busy != 0) for (int k = 0; k < N; k++) if (k != m_grant) m_grant = m_grant;
    end else if (hs) begin
      if (m_flushing == 0) pix[m_grant] = pix[m_grant] + 1'b1;
      m_cnt++;
      m_stall = 0;
      if (m_cnt == PIX) begin
        m_busy = 0;
        m_done = 1;
        m_flushed = m_flushing;
        m_flushing = 0;
      end
    end else if (m_flushing == 0 && !v[m_grant]) begin
      m_stall++;
`ifdef WINDOW_FRAME_ARBITER_FLUSH_EN
      if (m_stall == FT) begin
        m_flushing = 1;
        m_stall = 0;
      end
`endif
    end
    @(negedge clk);
  endtask
  task automatic reset_pixels();
    pix[0] = 8'h01;
    pix[1] = 8'h81;
  endtask
  initial begin
    int sent;
    model_reset();
    reset_pixels();
    #12;
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_grant", 32'(grant_o), 32'(N - 1));
    chk("reset_mvalid", 32'(master_valid_o), 32'd0);
    chk("reset_ready", 32'(src_ready_o), 32'd0);
    chk("reset_done", 32'(frame_done_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) step(2'b01, 1'b1);
    for (int i = 0; i < 4 * (PIX + 1) + 2; i++) step(2'b11, 1'b1);
    for (int i = 0; i < 2 * PIX + 6; i++) step(2'b01, 1'(i % 2 == 0));
    sent = 0;
    for (int i = 0; i < 40; i++) begin
      logic v0;
      v0 = !(sent >= 5 && i < 12);
      if (v0 && m_busy != 0 && m_grant == 0) sent++;
      step({1'b1, v0}, 1'b1);
    end
    for (int i = 0; i < 20; i++) step(2'b00, 1'b1);
    for (int i = 0; i < 7; i++) step(2'b01, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_busy", 32'(busy_o), 32'd0);
    chk("async_grant", 32'(grant_o), 32'(N - 1));
    chk("async_mvalid", 32'(master_valid_o), 32'd0);
    chk("async_ready", 32'(src_ready_o), 32'd0);
    chk("async_done", 32'(frame_done_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) step(2'b01, 1'b1);
`ifdef WINDOW_FRAME_ARBITER_FLUSH_EN
    sent = 0;
    for (int i = 0; i < 20; i++) begin
      step({1'b0, 1'(sent < 5)}, 1'b1);
      if (m_busy != 0) sent++;
    end
`endif
    for (int i = 0; i < 600; i++) step(N'($urandom), 1'($urandom_range(0, 3) != 0));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
